ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//  EX/MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Sits between the EX stage (ALU result plus the control bits carried out of ID/EX)
//  and the MEM stage.
//  Lets the data-memory side back-pressure EX without a combinational ready path
//  back through the pipe. A flush input kills in-flight entries on a taken branch.
// PARAMETERS
//  DATA_W  32  width of alu_result, store data and branch target
//  RD_W    5   destination-register index width
// PORTS
//  clk             in   1       pipeline clock, rising edge
//  reset           in   1       asynchronous, active-high reset
//  flush           in   1       synchronous kill of all held entries
//  in_valid        in   1       EX has a valid entry this cycle
//  in_ready        out  1       register can accept; registered output
//  reg_write_in    in   1       control: write back to register file
//  mem_to_reg_in   in   1       control: write-back source is memory
//  mem_write_in    in   1       control: store
//  mem_read_in     in   1       control: load
//  branch_in       in   1       control: instruction is a branch
//  zero_in         in   1       ALU zero flag
//  alu_result_in   in   DATA_W  ALU result / memory address
//  wr_data_in      in   DATA_W  store data (rt value)
//  br_target_in    in   DATA_W  branch target (nextpc + imm<<2, computed in EX)
//  rd_in           in   RD_W    destination register
//  out_valid       out  1       entry presented to MEM
//  out_ready       in   1       MEM accepts this cycle
//  *_out           out  -       registered copies of each *_in field above
//  br_taken_out    out  1       branch_out & zero_out, registered with the entry
//  stall_cnt       out  32      see CONFIGURATION (present only when macro is defined)
// BEHAVIOUR
//  - Storage: main slot drives the *_out ports; the skid slot is internal. Each slot
//    has a valid bit.
//  - State = {skid_v, main_v}: EMPTY(00), ONE(01), FULL(11). State 10 is illegal
//    and is never entered.
//  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
//  - in_ready is a register; next value is the inverse of the next skid_v.
//  - EMPTY + accept: main <= in, go to ONE. Latency in -> out_valid is 1 cycle.
//  - ONE:
//    - accept & drain: main <= in, stay in ONE.
//    - accept & !drain: skid <= in, go to FULL, in_ready -> 0.
//    - drain only: go to EMPTY.
//  - FULL: no accept is possible (in_ready = 0). On drain: main <= skid, skid_v <= 0,
//    go to ONE, in_ready -> 1.
//  - Ordering is strict FIFO; no entry is dropped or duplicated.
//  - flush (sync, highest priority): main_v and skid_v <= 0, in_ready <= 1. Any
//    same-cycle accept is discarded. A drain in the same cycle still completes
//    (MEM has already taken the entry).
//  - Data fields of invalid slots are don't-care, but out_valid = 0 must gate any
//    MEM-side effect. mem_write_out and reg_write_out are forced to 0 whenever
//    out_valid = 0.
//  - br_taken_out = branch & zero, captured at accept; it is not recomputed from
//    the _out registers.
//  - Reset (async, any time including mid-transfer): every output and internal
//    register is 0 except in_ready = 1. This gives state EMPTY. First accept is
//    possible on the first clk edge after reset falls.
//  - No combinational path from out_ready to in_ready or from in_valid to out_valid.
// CONFIGURATION
//  EX_MEM_STALL_CNT_EN defined:
//    - adds port stall_cnt [31:0]: counts cycles with out_valid & !out_ready.
//    - saturates at 32'hFFFF_FFFF; cleared by reset only, not by flush.
//  EX_MEM_STALL_CNT_EN undefined:
//    - port and counter are absent. All other behaviour is identical.
// TESTING
//  1. out_ready=1, 4 back-to-back accepts (alu_result 1,2,3,4):
//     -> out_valid from cycle+1; outputs 1,2,3,4 in order; in_ready stays 1.
//  2. Accept A=0x10; hold out_ready=0; accept B=0x20:
//     -> FULL, in_ready=0, out shows 0x10. Raise out_ready -> 0x10 then 0x20;
//     in_ready=1 one cycle after the first drain.
//  3. FULL state, then flush=1 with in_valid=1 (C=0x30):
//     -> next cycle out_valid=0, in_ready=1; C never appears at the output.
//  4. reset asserted mid-FULL, between clock edges:
//     -> immediately out_valid=0, mem_write_out=0, in_ready=1; first post-reset
//     accept appears normally.
//  5. branch_in=1, zero_in=1, br_target_in=0x40, entry held 3 cycles by out_ready=0:
//     -> br_taken_out=1 and br_target_out=0x40 stable all 3 cycles.
//  6. With EX_MEM_STALL_CNT_EN: 5 cycles of out_valid=1, out_ready=0:
//     -> stall_cnt=5. Preload near max -> sticks at 0xFFFF_FFFF.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer: 1-cycle in->out latency, registered in_ready drops only when both slots are full.
// Optional EX_MEM_STALL_CNT_EN adds a saturating count of back-pressured cycles.
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic              branch_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic [DATA_W-1:0] br_target_in,
  input  logic [RD_W-1:0]   rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              branch_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic [DATA_W-1:0] br_target_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              br_taken_out
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_read;
    logic              branch;
    logic              zero;
    logic              br_taken;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] br_target;
    logic [RD_W-1:0]   rd;
  } entry_t;

  // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_nx;
  entry_t in_ent, main_q, skid_q;
  logic   in_ready_q;
  logic   accept, drain;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ent = '{
    reg_write:  reg_write_in,
    mem_to_reg: mem_to_reg_in,
    mem_write:  mem_write_in,
    mem_read:   mem_read_in,
    branch:     branch_in,
    zero:       zero_in,
    br_taken:   branch_in & zero_in,
    alu_result: alu_result_in,
    wr_data:    wr_data_in,
    br_target:  br_target_in,
    rd:         rd_in
  };

  assign out_valid = state_q[0];
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nx       = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nx     = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nx  = FULL;
        end else if (drain) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_nx       = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // A drain alongside flush has already been taken by MEM; everything else dies.
    if (flush) begin
      state_nx       = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nx;
      in_ready_q <= ~state_nx[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_ent;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_ent;
      end
    end
  end

  // Side-effecting controls are gated so a stale slot can never write.
  assign reg_write_out  = main_q.reg_write & out_valid;
  assign mem_write_out  = main_q.mem_write & out_valid;
  assign mem_to_reg_out = main_q.mem_to_reg;
  assign mem_read_out   = main_q.mem_read;
  assign branch_out     = main_q.branch;
  assign zero_out       = main_q.zero;
  assign br_taken_out   = main_q.br_taken;
  assign alu_result_out = main_q.alu_result;
  assign wr_data_out    = main_q.wr_data;
  assign br_target_out  = main_q.br_target;
  assign rd_out         = main_q.rd;

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: a FIFO-of-entries model (capacity 2) predicts every output.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic        reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in, zero_in;
  logic [31:0] alu_result_in, wr_data_in, br_target_in;
  logic [4:0]  rd_in;
  logic        reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out, branch_out, zero_out;
  logic [31:0] alu_result_out, wr_data_out, br_target_out;
  logic [4:0]  rd_out;
  logic        br_taken_out;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .branch_in(branch_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .wr_data_in(wr_data_in),
    .br_target_in(br_target_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
    .branch_out(branch_out), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .wr_data_out(wr_data_out),
    .br_target_out(br_target_out), .rd_out(rd_out),
    .br_taken_out(br_taken_out)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] bt;
    logic [4:0]  rd;
    logic        rw, m2r, mw, mr, br, z;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_now = 0;
  bit          mon_en = 1'b0;
  logic [31:0] stall_exp = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.alu = $urandom; e.wd = $urandom; e.bt = $urandom;
    e.rd  = 5'($urandom);
    e.rw  = 1'($urandom); e.m2r = 1'($urandom); e.mw = 1'($urandom);
    e.mr  = 1'($urandom); e.br  = 1'($urandom); e.z  = 1'($urandom);
    return e;
  endfunction

  // Inputs change at negedge; the entry goes into the model when it will be accepted.
  task automatic drive(input bit iv, input bit ordy, input bit fl, input ent_t e);
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl;
    alu_result_in = e.alu; wr_data_in = e.wd; br_target_in = e.bt; rd_in = e.rd;
    reg_write_in = e.rw; mem_to_reg_in = e.m2r; mem_write_in = e.mw;
    mem_read_in = e.mr; branch_in = e.br; zero_in = e.z;
    if (iv && in_ready && !fl) begin
      q.push_back(e);
      acc_now = 1;
    end else begin
      acc_now = 0;
    end
  endtask

  task automatic idle(input bit ordy, input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = rand_ent();
      drive(1'b0, ordy, 1'b0, e);
    end
  endtask

  // Monitor: samples 2 time units after each negedge, i.e. the values the next posedge sees.
  initial begin
    int   vis;
    ent_t h;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !reset) begin
        vis = q.size() - acc_now;
        chk("out_valid", 32'(out_valid), 32'(vis > 0));
        chk("in_ready", 32'(in_ready), 32'(vis < 2));
        if (vis > 0) begin
          h = q[0];
          chk("alu_result", alu_result_out, h.alu);
          chk("wr_data", wr_data_out, h.wd);
          chk("br_target", br_target_out, h.bt);
          chk("rd", 32'(rd_out), 32'(h.rd));
          chk("ctrl", 32'({reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
                           branch_out, zero_out, br_taken_out}),
                      32'({h.rw, h.m2r, h.mw, h.mr, h.br, h.z, h.br & h.z}));
        end else begin
          chk("gated_writes", 32'({mem_write_out, reg_write_out}), 32'd0);
        end
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_exp);
`endif
        if (vis > 0 && !out_ready && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 32'd1;
        if (vis > 0 && out_ready) void'(q.pop_front());
        if (flush) q.delete();
      end
    end
  end

  initial begin
    ent_t e;
    int   n;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; mem_write_in = 1'b0; mem_read_in = 1'b0;
    branch_in = 1'b0; zero_in = 1'b0; alu_result_in = '0; wr_data_in = '0;
    br_target_in = '0; rd_in = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_ctrl", 32'({reg_write_out, mem_write_out, br_taken_out, rd_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Back-to-back stream with MEM always ready.
    for (int i = 1; i <= 4; i++) begin
      e = rand_ent(); e.alu = 32'(i);
      drive(1'b1, 1'b1, 1'b0, e);
    end
    idle(1'b1, 2);

    // Fill both slots under back-pressure, then drain.
    e = rand_ent(); e.alu = 32'h10; drive(1'b1, 1'b0, 1'b0, e);
    e = rand_ent(); e.alu = 32'h20; drive(1'b1, 1'b0, 1'b0, e);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // Flush while full, with a same-cycle offered entry.
    e = rand_ent(); drive(1'b1, 1'b0, 1'b0, e);
    e = rand_ent(); drive(1'b1, 1'b0, 1'b0, e);
    e = rand_ent(); e.alu = 32'h30; drive(1'b1, 1'b0, 1'b1, e);
    idle(1'b1, 2);

    // Asynchronous reset between edges while full.
    e = rand_ent(); e.mw = 1'b1; e.rw = 1'b1; drive(1'b1, 1'b0, 1'b0, e);
    e = rand_ent(); drive(1'b1, 1'b0, 1'b0, e);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; acc_now = 0;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_mem_write", 32'(mem_write_out), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    stall_exp = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    e = rand_ent(); e.alu = 32'h55; drive(1'b1, 1'b1, 1'b0, e);
    idle(1'b1, 1);

    // Taken branch held for 3 cycles.
    e = rand_ent(); e.br = 1'b1; e.z = 1'b1; e.bt = 32'h40;
    drive(1'b1, 1'b0, 1'b0, e);
    idle(1'b0, 3);
    chk("held_br_taken", 32'(br_taken_out), 32'd1);
    chk("held_br_target", br_target_out, 32'h40);
    idle(1'b1, 2);

    // Five stalled cycles for the optional counter.
    e = rand_ent(); drive(1'b1, 1'b0, 1'b0, e);
    idle(1'b0, 5);
    idle(1'b1, 2);

    repeat (600) begin
      e = rand_ent();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, e);
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin
      idle(1'b1, 1);
      n++;
    end
    idle(1'b1, 1);
    chk("final_out_valid", 32'(out_valid), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
